// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache controller with external tag/data arrays.
// Optional DCACHE_STATS_EN adds first-pass hit and miss counters.
module dcache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int OFFSET_W = 2,
  parameter int IDX_W = 5,
  parameter int DATA_W = 32,
  localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W,
  localparam int TAG_MEM_W = TAG_W + 2
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic [DATA_W-1:0]    cpu_rdata,
  output logic                 cpu_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ack,
  output logic                 tag_we,
  output logic [IDX_W-1:0]     idx,
  output logic [TAG_MEM_W-1:0] tag_wr,
  input  logic [TAG_MEM_W-1:0] tag_rd,
  output logic                 data_we,
  output logic [DATA_W-1:0]    data_wr,
  input  logic [DATA_W-1:0]    data_rd
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);
  localparam logic [2:0] INIT = 3'd0, IDLE = 3'd1, LOOKUP = 3'd2, WB = 3'd3, REFILL = 3'd4;
  logic [2:0] state, state_n;
  logic [IDX_W-1:0] cnt;
  logic [ADDR_W-OFFSET_W-1:0] line_q;
  logic we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TAG_W-1:0] tag_q;
  logic valid, dirty, hit, lookup, unused_ok;
  assign unused_ok = ^cpu_addr[OFFSET_W-1:0];
  assign tag_q = line_q[ADDR_W-OFFSET_W-1 -: TAG_W];
  assign valid = tag_rd[TAG_MEM_W-1];
  assign dirty = tag_rd[TAG_MEM_W-2];
  assign lookup = state == LOOKUP;
  assign hit = valid && tag_rd[TAG_W-1:0] == tag_q;
  assign idx = state == INIT ? cnt : line_q[IDX_W-1:0];
  assign cpu_ready = lookup && hit;
  assign cpu_rdata = lookup && hit && !we_q ? data_rd : '0;
  // refill fill and store hit share the write path; only refill leaves the line clean
  assign data_we = (lookup && hit && we_q) || (state == REFILL && mem_ack);
  assign data_wr = state == REFILL ? mem_rdata : wdata_q;
  assign tag_we = state == INIT || data_we;
  assign tag_wr = state == INIT ? '0 : {1'b1, state != REFILL, tag_q};
  assign mem_req = state == WB || state == REFILL;
  assign mem_we = state == WB;
  assign mem_addr = state == WB ? {tag_rd[TAG_W-1:0], idx, {OFFSET_W{1'b0}}} :
                    state == REFILL ? {line_q, {OFFSET_W{1'b0}}} : '0;
  assign mem_wdata = state == WB ? data_rd : '0;
  always_comb begin
    state_n = INIT;
    case (state)
      INIT:    state_n = &cnt ? IDLE : INIT;
      IDLE:    state_n = cpu_req ? LOOKUP : IDLE;
      LOOKUP:  state_n = hit ? IDLE : valid && dirty ? WB : REFILL;
      WB:      state_n = mem_ack ? REFILL : WB;
      REFILL:  state_n = mem_ack ? LOOKUP : REFILL;
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= INIT;
      cnt <= '0;
      line_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      cnt <= state == INIT ? cnt + 1'b1 : '0;
      if (state == IDLE && cpu_req) begin
        line_q <= cpu_addr[ADDR_W-1:OFFSET_W];
        we_q <= cpu_we;
        wdata_q <= cpu_wdata;
      end
    end
  end
`ifdef DCACHE_STATS_EN
  logic relook;
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      relook <= 1'b0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == IDLE && cpu_req) relook <= 1'b0;
      if (state == REFILL && mem_ack) relook <= 1'b1;
      if (lookup && hit && !relook) hit_cnt <= hit_cnt + 1'b1;
      if (lookup && !hit) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif
endmodule
